i2s_tx_fifo: RTL and testbench
==============================

I2S_TX_FIFO -- requirements
Module: i2s_tx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set sample width per channel; legal range 8..32.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set stereo-frame FIFO depth; power of two, 2..64.
REQ-003 Parameter HOLD_LAST, default 0, SHALL set underrun fill: 0 = zeros, 1 = repeat last popped frame.
REQ-004 clk_n  in  1  bit clock (BCLK); all flops SHALL update on its falling edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 daclrc  in  1  word clock from codec; 0 = left slot, 1 = right slot.
REQ-007 dacdat  out  1  serial data, MSB first, I2S format (one-bit delay).
REQ-008 in_left  in  DATA_WIDTH  left sample, two's complement.
REQ-009 in_right  in  DATA_WIDTH  right sample.
REQ-010 in_valid  in  1  frame offered.
REQ-011 in_ready  out  1  FIFO can accept; SHALL equal "FIFO not full".
REQ-012 mute  in  1  replace output samples with zero.
REQ-013 underrun  out  1  sticky underrun flag.
REQ-014 underrun_clr  in  1  single-cycle clear for underrun.
REQ-015 fifo_level  out  clog2(FIFO_DEPTH)+1  frames currently stored.

Function
REQ-016 A push SHALL occur on a falling clk_n edge where in_valid=1 and in_ready=1; {in_left,in_right} is stored as one frame.
REQ-017 daclrc SHALL be registered each cycle (lrc_q); an LRC edge is a cycle where daclrc != lrc_q.
REQ-018 A falling LRC edge (left start) SHALL pop one frame if fifo_level>0; the right sample SHALL come from the same frame.
REQ-019 Pop at left start with fifo_level=0 SHALL set underrun and load zeros (HOLD_LAST=0) or the previous frame (HOLD_LAST=1); fifo_level stays 0.
REQ-020 Push and pop in the same cycle SHALL leave fifo_level unchanged; with FIFO full, in_ready=0, so no push occurs.
REQ-021 mute sampled at a left-start edge SHALL zero both samples of that frame; the frame is still popped.
REQ-022 States: IDLE (dacdat=0, wait for first falling LRC edge), SHIFT (drive shift-register MSB, shift left each cycle), PAD (dacdat=0 until next LRC edge).
REQ-023 IDLE->SHIFT on falling LRC edge only; a rising edge in IDLE SHALL be ignored and no pop occurs.
REQ-024 On any LRC edge in SHIFT or PAD, the state SHALL be SHIFT and the shift register SHALL load the new channel sample; dacdat SHALL equal its MSB for that cycle.
REQ-025 SHIFT->PAD after DATA_WIDTH bits are driven; slots longer than DATA_WIDTH SHALL be zero-padded.
REQ-026 An LRC edge before DATA_WIDTH bits are driven SHALL truncate the current sample and start the next channel; the remaining bits are dropped.
REQ-027 underrun_clr=1 SHALL clear underrun; if a set event occurs in the same cycle, set SHALL win.
REQ-028 Latency: the left MSB SHALL appear on dacdat in the same cycle the falling LRC edge is detected.

Reset
REQ-029 rst=0 SHALL immediately force: state IDLE, FIFO empty, fifo_level=0, in_ready=0 during reset then 1, dacdat=0, underrun=0, lrc_q=0, hold frame=0.
REQ-030 Reset mid-frame SHALL discard the partial sample; after release, output resumes only at the next falling LRC edge.

Structure
REQ-031 The state encoding (IDLE/SHIFT/PAD) SHALL reside in shared package i2s_pkg.
REQ-032 The frame store SHALL be sub-module frame_fifo (width 2*DATA_WIDTH, depth FIFO_DEPTH, push/pop/full/empty/level).

Verification
REQ-033 Push left=16'hA5A5 and right=16'h5A5A, then send 32-BCLK frames -> left slot bits 1010010110100101 start at the edge-detect cycle; right slot likewise; level 1->0.
REQ-034 Start with FIFO empty and send one frame -> underrun=1 and all-zero slots; with HOLD_LAST=1, the prior frame repeats; underrun_clr pulse -> 0; clr coincident with a new underrun -> stays 1.
REQ-035 Push FIFO_DEPTH frames with no LRC -> in_ready=0 and level=4; a fifth valid is not accepted; one left edge -> level 3, in_ready=1 next cycle.
REQ-036 DATA_WIDTH=24 with 16-BCLK slots -> top 16 bits output, rest dropped; with 32-BCLK slots -> 24 bits then 8 zeros.
REQ-037 Assert mute before a left edge with sample 16'h7FFF queued -> zeros output and level decrements; deassert -> next frame plays.
REQ-038 Assert rst at bit 7 of the left slot -> dacdat=0 immediately and FIFO is empty; release, push a frame -> output resumes only at the next falling LRC edge, never at a rising edge.

Source files
------------

// File: rtl/i2s_tx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S transmit path with frame FIFO.
//   i2s_state_t : serializer state (IDLE / SHIFT / PAD), also exported on the
//                 top-level debug port o_state.
// ---------------------------------------------------------------------------
package i2s_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // waiting for the first left-slot start, dacdat = 0
      ST_SHIFT = 2'd1,   // driving shift-register MSB, shifting left
      ST_PAD   = 2'd2    // sample exhausted, dacdat = 0 until next LRC edge
   } i2s_state_t;

endpackage

// File: rtl/i2s_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// i2s_tx_fifo_if
// Stereo-frame input handshake for i2s_tx_fifo.
//   in_left / in_right : two's complement samples of one frame
//   in_valid           : source offers a frame
//   in_ready           : sink can accept (FIFO not full)
// Handshake: a frame transfers on a clock edge where in_valid and in_ready
// are both 1; the source holds data stable while in_valid is 1 and ready is 0.
//   master : frame source      slave : i2s_tx_fifo
// ---------------------------------------------------------------------------
interface i2s_tx_fifo_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] in_left;
   logic [DATA_WIDTH-1:0] in_right;
   logic                  in_valid;
   logic                  in_ready;

   modport master (output in_left, output in_right, output in_valid, input in_ready);
   modport slave  (input in_left, input in_right, input in_valid, output in_ready);
endinterface

// File: rtl/i2s_tx_fifo_frame_fifo.sv
// ---------------------------------------------------------------------------
// frame_fifo
// Synchronous FIFO of stereo frames, first-word fall-through read port.
// All flops update on the falling edge of clk_n.
//   clk_n, rst : bit clock, asynchronous active-low reset
//   i_push     : write i_wdata (ignored when full)
//   i_pop      : advance read pointer (ignored when empty)
//   o_rdata    : frame at the head of the queue
//   o_full, o_empty, o_level : occupancy
// ---------------------------------------------------------------------------
module frame_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk_n,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_level == (AW+1)'(DEPTH));
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_rdata = r_mem[r_rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(negedge clk_n or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage needs no reset: emptiness is tracked by r_level alone.
   always_ff @(negedge clk_n) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/i2s_tx_fifo.sv
// ---------------------------------------------------------------------------
// i2s_tx_fifo
// I2S DAC transmitter fed by a stereo-frame FIFO. Flops run on the falling
// edge of BCLK (clk_n). A falling daclrc edge starts the left slot and pops a
// frame; the following rising edge plays the right sample of the same frame.
//   clk_n        : bit clock (BCLK)
//   rst          : asynchronous active-low reset
//   daclrc       : word clock from codec, 0 = left, 1 = right
//   dacdat       : serial data, MSB first
//   s_in         : frame input handshake (in_left/in_right/in_valid/in_ready)
//   mute         : zero the frame popped at a left start
//   underrun     : sticky, set when a left start finds the FIFO empty
//   underrun_clr : clears underrun (a coincident set wins)
//   fifo_level   : frames stored
//   o_state      : serializer state, for observation
// ---------------------------------------------------------------------------
module i2s_tx_fifo
   import i2s_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int HOLD_LAST  = 0
) (
   input  logic                          clk_n,
   input  logic                          rst,
   input  logic                          daclrc,
   output logic                          dacdat,
   i2s_tx_fifo_if.slave                  s_in,
   input  logic                          mute,
   output logic                          underrun,
   input  logic                          underrun_clr,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output i2s_state_t                    o_state
);
   localparam int FW = 2 * DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   i2s_state_t            r_state;
   logic                  r_lrc_q;
   logic [DATA_WIDTH-1:0] r_sr;
   logic [CW-1:0]         r_cnt;
   logic [DATA_WIDTH-1:0] r_right;
   logic [FW-1:0]         r_hold;
   logic                  r_underrun;

   logic                  w_edge;
   logic                  w_left_start;
   logic                  w_right_start;
   logic                  w_load;
   logic                  w_push;
   logic                  w_full;
   logic                  w_empty;
   logic [FW-1:0]         w_head;
   logic [FW-1:0]         w_sel;
   logic [FW-1:0]         w_new_frame;
   logic [DATA_WIDTH-1:0] w_load_word;

   assign w_edge        = daclrc ^ r_lrc_q;
   assign w_left_start  = w_edge & ~daclrc;
   // A rising edge only starts a right slot once a left slot has been seen.
   assign w_right_start = w_edge & daclrc & (r_state != ST_IDLE);
   assign w_load        = w_left_start | w_right_start;

   assign s_in.in_ready = rst & ~w_full;
   assign w_push        = s_in.in_valid & s_in.in_ready;

   frame_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_frame_fifo (
      .clk_n   (clk_n),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata ({s_in.in_left, s_in.in_right}),
      .i_pop   (w_left_start),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (fifo_level)
   );

   // Underrun fill: zeros, or the last frame actually taken from the FIFO.
   assign w_sel       = !w_empty ? w_head : ((HOLD_LAST != 0) ? r_hold : '0);
   assign w_new_frame = mute ? '0 : w_sel;
   assign w_load_word = w_left_start ? w_new_frame[FW-1:DATA_WIDTH] : r_right;

   // The MSB is driven combinationally in the edge-detect cycle so the first
   // bit of a slot appears without an extra register stage.
   always_comb begin
      dacdat = 1'b0;
      if (w_load)                    dacdat = w_load_word[DATA_WIDTH-1];
      else if (r_state == ST_SHIFT)  dacdat = r_sr[DATA_WIDTH-1];
   end

   // Serializer FSM. r_cnt is the index of the bit driven in the current
   // SHIFT cycle; bit 0 went out in the load cycle.
   always_ff @(negedge clk_n or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_lrc_q <= 1'b0;
         r_sr    <= '0;
         r_cnt   <= '0;
         r_right <= '0;
         r_hold  <= '0;
      end else begin
         r_lrc_q <= daclrc;
         if (w_left_start) begin
            r_right <= w_new_frame[DATA_WIDTH-1:0];
            if (!w_empty) r_hold <= w_head;
         end
         if (w_load) begin
            // Any slot start overrides the current sample (truncation).
            r_state <= ST_SHIFT;
            r_sr    <= {w_load_word[DATA_WIDTH-2:0], 1'b0};
            r_cnt   <= CW'(1);
         end else begin
            case (r_state)
               ST_SHIFT: begin
                  r_sr <= {r_sr[DATA_WIDTH-2:0], 1'b0};
                  if (r_cnt == CW'(DATA_WIDTH-1)) r_state <= ST_PAD;
                  else                            r_cnt   <= r_cnt + 1'b1;
               end
               default: r_state <= r_state;
            endcase
         end
      end
   end

   always_ff @(negedge clk_n or negedge rst) begin
      if (!rst)                         r_underrun <= 1'b0;
      else if (w_left_start && w_empty) r_underrun <= 1'b1;
      else if (underrun_clr)            r_underrun <= 1'b0;
   end

   assign underrun = r_underrun;
   assign o_state  = r_state;

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx_fifo
// Directed bench for i2s_tx_fifo. Three instances share clock, reset, word
// clock, mute and clear:
//   dut0 : 16-bit, depth 4, zero fill on underrun
//   dut1 : 16-bit, depth 4, repeat last frame on underrun
//   dut2 : 24-bit, depth 4, zero fill on underrun
// Inputs change 1 time unit after the falling clk_n edge; dacdat is sampled
// on the rising edge, registered outputs are read 1 unit after the fall.
// ---------------------------------------------------------------------------
module tb_i2s_tx_fifo;
   import i2s_pkg::*;

   logic       clk_n        = 1'b1;
   logic       rst          = 1'b0;
   logic       daclrc       = 1'b0;
   logic       mute         = 1'b0;
   logic       underrun_clr = 1'b0;

   logic       dacdat0, dacdat1, dacdat2;
   logic       und0, und1, und2;
   logic [2:0] lvl0, lvl1, lvl2;
   i2s_state_t st0, st1, st2;

   int n_vec = 0;
   int n_err = 0;

   i2s_tx_fifo_if #(.DATA_WIDTH(16)) if0 ();
   i2s_tx_fifo_if #(.DATA_WIDTH(16)) if1 ();
   i2s_tx_fifo_if #(.DATA_WIDTH(24)) if2 ();

   always #5 clk_n = ~clk_n;

   i2s_tx_fifo #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .HOLD_LAST(0)) dut0 (
      .clk_n(clk_n), .rst(rst), .daclrc(daclrc), .dacdat(dacdat0), .s_in(if0),
      .mute(mute), .underrun(und0), .underrun_clr(underrun_clr),
      .fifo_level(lvl0), .o_state(st0));

   i2s_tx_fifo #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .HOLD_LAST(1)) dut1 (
      .clk_n(clk_n), .rst(rst), .daclrc(daclrc), .dacdat(dacdat1), .s_in(if1),
      .mute(mute), .underrun(und1), .underrun_clr(underrun_clr),
      .fifo_level(lvl1), .o_state(st1));

   i2s_tx_fifo #(.DATA_WIDTH(24), .FIFO_DEPTH(4), .HOLD_LAST(0)) dut2 (
      .clk_n(clk_n), .rst(rst), .daclrc(daclrc), .dacdat(dacdat2), .s_in(if2),
      .mute(mute), .underrun(und2), .underrun_clr(underrun_clr),
      .fifo_level(lvl2), .o_state(st2));

   // ---------------- clock / reset / drivers ----------------
   task automatic next_cycle();
      @(negedge clk_n);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b0;
      daclrc       = 1'b0;
      mute         = 1'b0;
      underrun_clr = 1'b0;
      if0.in_valid = 1'b0;
      if1.in_valid = 1'b0;
      if2.in_valid = 1'b0;
      repeat (2) next_cycle();
      rst = 1'b1;
      next_cycle();
   endtask

   task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
      if0.in_left = l; if0.in_right = r; if0.in_valid = 1'b1;
      if1.in_left = l; if1.in_right = r; if1.in_valid = 1'b1;
      next_cycle();
      if0.in_valid = 1'b0;
      if1.in_valid = 1'b0;
   endtask

   task automatic push24(input logic [23:0] l, input logic [23:0] r);
      if2.in_left = l; if2.in_right = r; if2.in_valid = 1'b1;
      next_cycle();
      if2.in_valid = 1'b0;
   endtask

   // Drives one slot of nbits BCLK cycles; returns the captured bits, first
   // bit ends up most significant. underrun_clr is dropped after cycle 0.
   task automatic send_slot(input logic lr, input int nbits,
                            output logic [63:0] b0, output logic [63:0] b1,
                            output logic [63:0] b2);
      b0 = '0; b1 = '0; b2 = '0;
      daclrc = lr;
      for (int i = 0; i < nbits; i++) begin
         @(posedge clk_n);
         b0 = {b0[62:0], dacdat0};
         b1 = {b1[62:0], dacdat1};
         b2 = {b2[62:0], dacdat2};
         next_cycle();
         underrun_clr = 1'b0;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst    = 1'b0;
      daclrc = 1'b1;
      repeat (2) next_cycle();
      n_vec++; if (dacdat0 !== 1'b0) begin n_err++; $display("FAIL rst_dacdat: got %b want 0", dacdat0); end
      n_vec++; if (und0 !== 1'b0) begin n_err++; $display("FAIL rst_underrun: got %b want 0", und0); end
      n_vec++; if (lvl0 !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", lvl0); end
      n_vec++; if (if0.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready_low: got %b want 0", if0.in_ready); end
      n_vec++; if (st0 !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want %0d", st0, ST_IDLE); end
      daclrc = 1'b0;
      rst    = 1'b1;
      #1;
      n_vec++; if (if0.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready_high: got %b want 1", if0.in_ready); end
      next_cycle();
   endtask

   task automatic test_basic();
      logic [63:0] b0, b1, b2;
      do_reset();
      push_frame(16'hA5A5, 16'h5A5A);
      n_vec++; if (lvl0 !== 3'd1) begin n_err++; $display("FAIL basic_level_push: got %0d want 1", lvl0); end
      send_slot(1'b1, 16, b0, b1, b2);
      n_vec++; if (b0[15:0] !== 16'h0000) begin n_err++; $display("FAIL basic_idle_rise: got %h want 0000", b0[15:0]); end
      n_vec++; if (lvl0 !== 3'd1) begin n_err++; $display("FAIL basic_no_pop_rise: got %0d want 1", lvl0); end
      send_slot(1'b0, 16, b0, b1, b2);
      n_vec++; if (b0[15:0] !== 16'hA5A5) begin n_err++; $display("FAIL basic_left: got %h want a5a5", b0[15:0]); end
      n_vec++; if (lvl0 !== 3'd0) begin n_err++; $display("FAIL basic_level_pop: got %0d want 0", lvl0); end
      send_slot(1'b1, 16, b0, b1, b2);
      n_vec++; if (b0[15:0] !== 16'h5A5A) begin n_err++; $display("FAIL basic_right: got %h want 5a5a", b0[15:0]); end
      n_vec++; if (und0 !== 1'b0) begin n_err++; $display("FAIL basic_no_underrun: got %b want 0", und0); end
   endtask

   task automatic test_underrun();
      logic [63:0] b0, b1, b2;
      do_reset();
      push_frame(16'h1234, 16'hABCD);
      send_slot(1'b1, 16, b0, b1, b2);
      send_slot(1'b0, 16, b0, b1, b2);
      n_vec++; if (b1[15:0] !== 16'h1234) begin n_err++; $display("FAIL ur_hold_first_left: got %h want 1234", b1[15:0]); end
      send_slot(1'b1, 16, b0, b1, b2);
      n_vec++; if (und0 !== 1'b0) begin n_err++; $display("FAIL ur_clear_before: got %b want 0", und0); end
      send_slot(1'b0, 16, b0, b1, b2);
      n_vec++; if (b0[15:0] !== 16'h0000) begin n_err++; $display("FAIL ur_zero_left: got %h want 0000", b0[15:0]); end
      n_vec++; if (b1[15:0] !== 16'h1234) begin n_err++; $display("FAIL ur_hold_left: got %h want 1234", b1[15:0]); end
      n_vec++; if (und0 !== 1'b1) begin n_err++; $display("FAIL ur_set0: got %b want 1", und0); end
      n_vec++; if (und1 !== 1'b1) begin n_err++; $display("FAIL ur_set1: got %b want 1", und1); end
      n_vec++; if (lvl1 !== 3'd0) begin n_err++; $display("FAIL ur_level_stays: got %0d want 0", lvl1); end
      send_slot(1'b1, 16, b0, b1, b2);
      n_vec++; if (b0[15:0] !== 16'h0000) begin n_err++; $display("FAIL ur_zero_right: got %h want 0000", b0[15:0]); end
      n_vec++; if (b1[15:0] !== 16'hABCD) begin n_err++; $display("FAIL ur_hold_right: got %h want abcd", b1[15:0]); end
      underrun_clr = 1'b1;
      next_cycle();
      underrun_clr = 1'b0;
      n_vec++; if (und0 !== 1'b0) begin n_err++; $display("FAIL ur_clr_pulse: got %b want 0", und0); end
      underrun_clr = 1'b1;
      send_slot(1'b0, 16, b0, b1, b2);
      n_vec++; if (und0 !== 1'b1) begin n_err++; $display("FAIL ur_set_wins: got %b want 1", und0); end
   endtask

   task automatic test_full();
      logic [63:0] b0, b1, b2;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (if0.in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_%0d: got %b want 1", i, if0.in_ready); end
         push_frame(16'h1000 + 16'(i), 16'h2000 + 16'(i));
      end
      n_vec++; if (lvl0 !== 3'd4) begin n_err++; $display("FAIL full_level4: got %0d want 4", lvl0); end
      n_vec++; if (if0.in_ready !== 1'b0) begin n_err++; $display("FAIL full_not_ready: got %b want 0", if0.in_ready); end
      push_frame(16'hDEAD, 16'hBEEF);
      n_vec++; if (lvl0 !== 3'd4) begin n_err++; $display("FAIL full_fifth_rejected: got %0d want 4", lvl0); end
      daclrc = 1'b1;
      next_cycle();
      n_vec++; if (lvl0 !== 3'd4) begin n_err++; $display("FAIL full_rise_no_pop: got %0d want 4", lvl0); end
      daclrc = 1'b0;
      next_cycle();
      n_vec++; if (lvl0 !== 3'd3) begin n_err++; $display("FAIL full_level3: got %0d want 3", lvl0); end
      n_vec++; if (if0.in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_again: got %b want 1", if0.in_ready); end
      send_slot(1'b0, 15, b0, b1, b2);
      n_vec++; if (b0[14:0] !== 15'h1000) begin n_err++; $display("FAIL full_first_left: got %h want 1000", b0[14:0]); end
      send_slot(1'b1, 16, b0, b1, b2);
      n_vec++; if (b0[15:0] !== 16'h2000) begin n_err++; $display("FAIL full_first_right: got %h want 2000", b0[15:0]); end
      send_slot(1'b0, 16, b0, b1, b2);
      n_vec++; if (b0[15:0] !== 16'h1001) begin n_err++; $display("FAIL full_order: got %h want 1001", b0[15:0]); end
   endtask

   task automatic test_width24();
      logic [63:0] b0, b1, b2;
      do_reset();
      push24(24'hABCDEF, 24'h123456);
      push24(24'hC0FFEE, 24'h0F1E2D);
      n_vec++; if (lvl2 !== 3'd2) begin n_err++; $display("FAIL w24_level: got %0d want 2", lvl2); end
      send_slot(1'b1, 16, b0, b1, b2);
      send_slot(1'b0, 16, b0, b1, b2);
      n_vec++; if (b2[15:0] !== 16'hABCD) begin n_err++; $display("FAIL w24_trunc_left: got %h want abcd", b2[15:0]); end
      send_slot(1'b1, 16, b0, b1, b2);
      n_vec++; if (b2[15:0] !== 16'h1234) begin n_err++; $display("FAIL w24_trunc_right: got %h want 1234", b2[15:0]); end
      send_slot(1'b0, 32, b0, b1, b2);
      n_vec++; if (b2[31:0] !== 32'hC0FFEE00) begin n_err++; $display("FAIL w24_pad_left: got %h want c0ffee00", b2[31:0]); end
      send_slot(1'b1, 32, b0, b1, b2);
      n_vec++; if (b2[31:0] !== 32'h0F1E2D00) begin n_err++; $display("FAIL w24_pad_right: got %h want 0f1e2d00", b2[31:0]); end
      n_vec++; if (lvl2 !== 3'd0) begin n_err++; $display("FAIL w24_level_end: got %0d want 0", lvl2); end
   endtask

   task automatic test_mute();
      logic [63:0] b0, b1, b2;
      do_reset();
      push_frame(16'h7FFF, 16'h7FFF);
      push_frame(16'h1357, 16'h2468);
      send_slot(1'b1, 16, b0, b1, b2);
      mute = 1'b1;
      send_slot(1'b0, 16, b0, b1, b2);
      n_vec++; if (b0[15:0] !== 16'h0000) begin n_err++; $display("FAIL mute_left: got %h want 0000", b0[15:0]); end
      n_vec++; if (lvl0 !== 3'd1) begin n_err++; $display("FAIL mute_level: got %0d want 1", lvl0); end
      mute = 1'b0;
      send_slot(1'b1, 16, b0, b1, b2);
      n_vec++; if (b0[15:0] !== 16'h0000) begin n_err++; $display("FAIL mute_right: got %h want 0000", b0[15:0]); end
      send_slot(1'b0, 16, b0, b1, b2);
      n_vec++; if (b0[15:0] !== 16'h1357) begin n_err++; $display("FAIL unmute_left: got %h want 1357", b0[15:0]); end
      send_slot(1'b1, 16, b0, b1, b2);
      n_vec++; if (b0[15:0] !== 16'h2468) begin n_err++; $display("FAIL unmute_right: got %h want 2468", b0[15:0]); end
      n_vec++; if (und0 !== 1'b0) begin n_err++; $display("FAIL mute_no_underrun: got %b want 0", und0); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] b0, b1, b2;
      logic        first_bit;
      do_reset();
      push_frame(16'h8001, 16'h4002);
      send_slot(1'b1, 16, b0, b1, b2);
      // Left-start edge and a push in the same cycle.
      daclrc = 1'b0;
      if0.in_left = 16'hBEEF; if0.in_right = 16'hCAFE; if0.in_valid = 1'b1;
      if1.in_left = 16'hBEEF; if1.in_right = 16'hCAFE; if1.in_valid = 1'b1;
      @(posedge clk_n);
      first_bit = dacdat0;
      next_cycle();
      if0.in_valid = 1'b0;
      if1.in_valid = 1'b0;
      n_vec++; if (first_bit !== 1'b1) begin n_err++; $display("FAIL b2b_msb_latency: got %b want 1", first_bit); end
      n_vec++; if (lvl0 !== 3'd1) begin n_err++; $display("FAIL b2b_level: got %0d want 1", lvl0); end
      send_slot(1'b0, 15, b0, b1, b2);
      n_vec++; if (b0[14:0] !== 15'h0001) begin n_err++; $display("FAIL b2b_left_rest: got %h want 0001", b0[14:0]); end
      send_slot(1'b1, 16, b0, b1, b2);
      n_vec++; if (b0[15:0] !== 16'h4002) begin n_err++; $display("FAIL b2b_right: got %h want 4002", b0[15:0]); end
      send_slot(1'b0, 16, b0, b1, b2);
      n_vec++; if (b0[15:0] !== 16'hBEEF) begin n_err++; $display("FAIL b2b_second_left: got %h want beef", b0[15:0]); end
      send_slot(1'b1, 16, b0, b1, b2);
      n_vec++; if (b0[15:0] !== 16'hCAFE) begin n_err++; $display("FAIL b2b_second_right: got %h want cafe", b0[15:0]); end
   endtask

   task automatic test_reset_midframe();
      logic [63:0] b0, b1, b2;
      do_reset();
      push_frame(16'h1357, 16'h5678);
      send_slot(1'b1, 16, b0, b1, b2);
      send_slot(1'b0, 7, b0, b1, b2);
      n_vec++; if (b0[6:0] !== 7'h09) begin n_err++; $display("FAIL mid_partial: got %h want 09", b0[6:0]); end
      n_vec++; if (dacdat0 !== 1'b1) begin n_err++; $display("FAIL mid_bit7_before: got %b want 1", dacdat0); end
      rst = 1'b0;
      #1;
      n_vec++; if (dacdat0 !== 1'b0) begin n_err++; $display("FAIL mid_dacdat_now: got %b want 0", dacdat0); end
      n_vec++; if (lvl0 !== 3'd0) begin n_err++; $display("FAIL mid_fifo_empty: got %0d want 0", lvl0); end
      n_vec++; if (st0 !== ST_IDLE) begin n_err++; $display("FAIL mid_state: got %0d want %0d", st0, ST_IDLE); end
      repeat (2) next_cycle();
      rst = 1'b1;
      next_cycle();
      push_frame(16'h9ABC, 16'hDEF0);
      send_slot(1'b1, 16, b0, b1, b2);
      n_vec++; if (b0[15:0] !== 16'h0000) begin n_err++; $display("FAIL mid_no_rise_start: got %h want 0000", b0[15:0]); end
      n_vec++; if (lvl0 !== 3'd1) begin n_err++; $display("FAIL mid_level_kept: got %0d want 1", lvl0); end
      send_slot(1'b0, 16, b0, b1, b2);
      n_vec++; if (b0[15:0] !== 16'h9ABC) begin n_err++; $display("FAIL mid_resume_left: got %h want 9abc", b0[15:0]); end
      n_vec++; if (lvl0 !== 3'd0) begin n_err++; $display("FAIL mid_level_pop: got %0d want 0", lvl0); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      if0.in_left = '0; if0.in_right = '0; if0.in_valid = 1'b0;
      if1.in_left = '0; if1.in_right = '0; if1.in_valid = 1'b0;
      if2.in_left = '0; if2.in_right = '0; if2.in_valid = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_underrun();
      test_full();
      test_width24();
      test_mute();
      test_back_to_back();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, vectors %0d", n_vec);
      $fatal(1);
   end

endmodule
